// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU; wakes operands from two CDBs, issues one per cycle.
// Optional macro RS_WAKEUP_BYPASS_EN lets an entry issue on the same edge its last operand is broadcast.
module rs_alu #(
  parameter int RS_SIZE = 8,
  parameter int RS_BIT  = 3,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               disp_valid,
  input  logic [2:0]         disp_op,
  input  logic [6:0]         disp_op_type,
  input  logic               disp_op_addition,
  input  logic [31:0]        disp_vi,
  input  logic [31:0]        disp_vj,
  input  logic               disp_has_qi,
  input  logic               disp_has_qj,
  input  logic [ROB_BIT-1:0] disp_qi,
  input  logic [ROB_BIT-1:0] disp_qj,
  input  logic [ROB_BIT-1:0] disp_rob_entry,
  output logic               full,
  input  logic               alu_cdb_ready,
  input  logic [31:0]        alu_cdb_res,
  input  logic [ROB_BIT-1:0] alu_cdb_rob,
  input  logic               lsb_cdb_ready,
  input  logic [31:0]        lsb_cdb_res,
  input  logic [ROB_BIT-1:0] lsb_cdb_rob,
  output logic               valid,
  output logic [31:0]        vi,
  output logic [31:0]        vj,
  output logic [2:0]         op,
  output logic [6:0]         op_type,
  output logic               op_addition,
  output logic [ROB_BIT-1:0] rob_entry
);
  localparam int DATA_W = 32;

  logic [RS_SIZE-1:0] busy_p0, pend_i_p0, pend_j_p0;
  logic [DATA_W-1:0]  vi_p0 [RS_SIZE];
  logic [DATA_W-1:0]  vj_p0 [RS_SIZE];
  logic [ROB_BIT-1:0] qi_p0 [RS_SIZE];
  logic [ROB_BIT-1:0] qj_p0 [RS_SIZE];
  logic [ROB_BIT-1:0] rob_p0 [RS_SIZE];
  logic [2:0]         op_p0 [RS_SIZE];
  logic [6:0]         op_type_p0 [RS_SIZE];
  logic [RS_SIZE-1:0] op_add_p0;

  logic [RS_SIZE-1:0] wake_i, wake_j, cand;
  logic [DATA_W-1:0]  bus_i [RS_SIZE];
  logic [DATA_W-1:0]  bus_j [RS_SIZE];
  logic               sel_ok, disp_go, disp_hit_i, disp_hit_j;
  logic [RS_BIT-1:0]  sel_idx, free_idx;
  logic [DATA_W-1:0]  iss_vi, iss_vj, disp_bus_i, disp_bus_j;

  function automatic logic tag_hit(input logic [ROB_BIT-1:0] tag,
                                   input logic a_rdy, input logic [ROB_BIT-1:0] a_rob,
                                   input logic l_rdy, input logic [ROB_BIT-1:0] l_rob);
    return (a_rdy && (tag == a_rob)) || (l_rdy && (tag == l_rob));
  endfunction

  // ALU bus takes precedence; a tag matching both buses at once never occurs
  function automatic logic [DATA_W-1:0] tag_val(input logic [ROB_BIT-1:0] tag,
                                                input logic a_rdy, input logic [ROB_BIT-1:0] a_rob,
                                                input logic [DATA_W-1:0] a_res,
                                                input logic [DATA_W-1:0] l_res);
    return (a_rdy && (tag == a_rob)) ? a_res : l_res;
  endfunction

  assign full = &busy_p0;

  always_comb begin
    for (int k = 0; k < RS_SIZE; k++) begin
      wake_i[k] = busy_p0[k] && pend_i_p0[k] &&
                  tag_hit(qi_p0[k], alu_cdb_ready, alu_cdb_rob, lsb_cdb_ready, lsb_cdb_rob);
      wake_j[k] = busy_p0[k] && pend_j_p0[k] &&
                  tag_hit(qj_p0[k], alu_cdb_ready, alu_cdb_rob, lsb_cdb_ready, lsb_cdb_rob);
      bus_i[k]  = tag_val(qi_p0[k], alu_cdb_ready, alu_cdb_rob, alu_cdb_res, lsb_cdb_res);
      bus_j[k]  = tag_val(qj_p0[k], alu_cdb_ready, alu_cdb_rob, alu_cdb_res, lsb_cdb_res);
    end
`ifdef RS_WAKEUP_BYPASS_EN
    cand = busy_p0 & (~pend_i_p0 | wake_i) & (~pend_j_p0 | wake_j);
`else
    cand = busy_p0 & ~pend_i_p0 & ~pend_j_p0;
`endif
    sel_ok   = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int k = RS_SIZE - 1; k >= 0; k--) begin
      if (cand[k]) begin
        sel_ok  = 1'b1;
        sel_idx = RS_BIT'(k);
      end
      if (!busy_p0[k]) free_idx = RS_BIT'(k);
    end
`ifdef RS_WAKEUP_BYPASS_EN
    iss_vi = wake_i[sel_idx] ? bus_i[sel_idx] : vi_p0[sel_idx];
    iss_vj = wake_j[sel_idx] ? bus_j[sel_idx] : vj_p0[sel_idx];
`else
    iss_vi = vi_p0[sel_idx];
    iss_vj = vj_p0[sel_idx];
`endif
    disp_go    = disp_valid && !full;
    disp_hit_i = disp_has_qi && tag_hit(disp_qi, alu_cdb_ready, alu_cdb_rob, lsb_cdb_ready, lsb_cdb_rob);
    disp_hit_j = disp_has_qj && tag_hit(disp_qj, alu_cdb_ready, alu_cdb_rob, lsb_cdb_ready, lsb_cdb_rob);
    disp_bus_i = tag_val(disp_qi, alu_cdb_ready, alu_cdb_rob, alu_cdb_res, lsb_cdb_res);
    disp_bus_j = tag_val(disp_qj, alu_cdb_ready, alu_cdb_rob, alu_cdb_res, lsb_cdb_res);
  end

  // Stage p0 -> issue registers: busy/pending bookkeeping and the registered issue port
  always_ff @(posedge clk_in) begin
    if (rst_in || rob_clear_up) begin
      busy_p0     <= '0;
      pend_i_p0   <= '0;
      pend_j_p0   <= '0;
      valid       <= 1'b0;
      vi          <= '0;
      vj          <= '0;
      op          <= '0;
      op_type     <= '0;
      op_addition <= 1'b0;
      rob_entry   <= '0;
    end else if (rdy_in) begin
      pend_i_p0 <= pend_i_p0 & ~wake_i;
      pend_j_p0 <= pend_j_p0 & ~wake_j;
      valid     <= sel_ok;
      if (sel_ok) begin
        busy_p0[sel_idx] <= 1'b0;
        vi               <= iss_vi;
        vj               <= iss_vj;
        op               <= op_p0[sel_idx];
        op_type          <= op_type_p0[sel_idx];
        op_addition      <= op_add_p0[sel_idx];
        rob_entry        <= rob_p0[sel_idx];
      end
      if (disp_go) begin
        busy_p0[free_idx]   <= 1'b1;
        pend_i_p0[free_idx] <= disp_has_qi && !disp_hit_i;
        pend_j_p0[free_idx] <= disp_has_qj && !disp_hit_j;
      end
    end
  end

  // Stage p0 entry payload: written on dispatch and on wakeup, never reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && !rob_clear_up) begin
      for (int k = 0; k < RS_SIZE; k++) begin
        if (wake_i[k]) vi_p0[k] <= bus_i[k];
        if (wake_j[k]) vj_p0[k] <= bus_j[k];
      end
      if (disp_go) begin
        vi_p0[free_idx]      <= disp_has_qi ? disp_bus_i : disp_vi;
        vj_p0[free_idx]      <= disp_has_qj ? disp_bus_j : disp_vj;
        qi_p0[free_idx]      <= disp_qi;
        qj_p0[free_idx]      <= disp_qj;
        rob_p0[free_idx]     <= disp_rob_entry;
        op_p0[free_idx]      <= disp_op;
        op_type_p0[free_idx] <= disp_op_type;
        op_add_p0[free_idx]  <= disp_op_addition;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: cycle tables for the directed scenarios, then randomized traffic against an entry-list model.
`timescale 1ns/1ps
module tb_rs_alu;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int ALU = 'b0110011;
  localparam int BR  = 'b1100011;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, rdy_in, rob_clear_up, disp_valid, disp_op_addition;
  logic [2:0]  disp_op;
  logic [6:0]  disp_op_type;
  logic [31:0] disp_vi, disp_vj, alu_cdb_res, lsb_cdb_res;
  logic        disp_has_qi, disp_has_qj, alu_cdb_ready, lsb_cdb_ready;
  logic [3:0]  disp_qi, disp_qj, disp_rob_entry, alu_cdb_rob, lsb_cdb_rob;
  logic        full, valid, op_addition;
  logic [31:0] vi, vj;
  logic [2:0]  op;
  logic [6:0]  op_type;
  logic [3:0]  rob_entry;

  rs_alu #(.RS_SIZE(8), .RS_BIT(3), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_op_type(disp_op_type),
    .disp_op_addition(disp_op_addition), .disp_vi(disp_vi), .disp_vj(disp_vj),
    .disp_has_qi(disp_has_qi), .disp_has_qj(disp_has_qj), .disp_qi(disp_qi), .disp_qj(disp_qj),
    .disp_rob_entry(disp_rob_entry), .full(full),
    .alu_cdb_ready(alu_cdb_ready), .alu_cdb_res(alu_cdb_res), .alu_cdb_rob(alu_cdb_rob),
    .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_res(lsb_cdb_res), .lsb_cdb_rob(lsb_cdb_rob),
    .valid(valid), .vi(vi), .vj(vj), .op(op), .op_type(op_type),
    .op_addition(op_addition), .rob_entry(rob_entry)
  );

  typedef struct {
    logic rst, rdy, clr, dv;
    logic [2:0] op; logic [6:0] opt; logic add;
    logic [31:0] dvi, dvj; logic hqi, hqj; logic [3:0] qi, qj, rob;
    logic ac; logic [31:0] ares; logic [3:0] arob;
    logic lc; logic [31:0] lres; logic [3:0] lrob;
  } in_t;

  typedef struct {
    in_t i; logic chk_all; logic e_valid; logic [31:0] e_vi, e_vj; logic [3:0] e_rob;
    logic [2:0] e_op; logic [6:0] e_opt; logic e_add; logic e_full;
  } vec_t;

  typedef struct {
    bit busy, pi, pj; logic [31:0] vi, vj; logic [3:0] qi, qj, rob;
    logic [2:0] op; logic [6:0] opt; logic add;
  } ment_t;

  int checks = 0, errors = 0;
  vec_t tbl[$];
  ment_t m [8];
  logic ev, eadd; logic [31:0] evi, evj; logic [3:0] erob; logic [2:0] eop; logic [6:0] eopt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t t;
    t = '{default: '0};
    t.rdy = 1'b1;
    return t;
  endfunction

  function automatic in_t dsp(input in_t t0, input int o, input int ot, input int ad, input int a,
                              input int b, input int hqi, input int qi, input int hqj, input int qj,
                              input int rob);
    in_t t = t0;
    t.dv = 1'b1; t.op = 3'(o); t.opt = 7'(ot); t.add = 1'(ad);
    t.dvi = 32'(a); t.dvj = 32'(b); t.hqi = 1'(hqi); t.qi = 4'(qi);
    t.hqj = 1'(hqj); t.qj = 4'(qj); t.rob = 4'(rob);
    return t;
  endfunction

  function automatic in_t alu(input in_t t0, input int rob, input int res);
    in_t t = t0;
    t.ac = 1'b1; t.arob = 4'(rob); t.ares = 32'(res);
    return t;
  endfunction

  function automatic in_t lsb(input in_t t0, input int rob, input int res);
    in_t t = t0;
    t.lc = 1'b1; t.lrob = 4'(rob); t.lres = 32'(res);
    return t;
  endfunction

  function automatic vec_t ex(input in_t t, input int v, input int a, input int b, input int rob,
                              input int ad, input int f);
    vec_t r;
    r.i = t; r.chk_all = 1'b0; r.e_valid = 1'(v); r.e_vi = 32'(a); r.e_vj = 32'(b);
    r.e_rob = 4'(rob); r.e_op = 3'd0; r.e_opt = 7'(ALU); r.e_add = 1'(ad); r.e_full = 1'(f);
    return r;
  endfunction

  function automatic vec_t nx(input in_t t, input int f);
    return ex(t, 0, 0, 0, 0, 0, f);
  endfunction

  function automatic vec_t rz(input in_t t);
    vec_t r = ex(t, 0, 0, 0, 0, 0, 0);
    r.chk_all = 1'b1; r.e_opt = 7'd0;
    return r;
  endfunction

  // Operand arrival on the edge: one cycle later normally, on the same edge with bypass
  task automatic wake_pair(input in_t tb, input int a, input int b, input int rob, input int ad);
    if (BYP) begin
      tbl.push_back(ex(tb, 1, a, b, rob, ad, 0));
      tbl.push_back(nx(idle(), 0));
    end else begin
      tbl.push_back(nx(tb, 0));
      tbl.push_back(ex(idle(), 1, a, b, rob, ad, 0));
    end
  endtask

  task automatic drive(input in_t t);
    rst_in = t.rst; rdy_in = t.rdy; rob_clear_up = t.clr; disp_valid = t.dv;
    disp_op = t.op; disp_op_type = t.opt; disp_op_addition = t.add;
    disp_vi = t.dvi; disp_vj = t.dvj; disp_has_qi = t.hqi; disp_has_qj = t.hqj;
    disp_qi = t.qi; disp_qj = t.qj; disp_rob_entry = t.rob;
    alu_cdb_ready = t.ac; alu_cdb_res = t.ares; alu_cdb_rob = t.arob;
    lsb_cdb_ready = t.lc; lsb_cdb_res = t.lres; lsb_cdb_rob = t.lrob;
  endtask

  function automatic bit hit(input in_t t, input logic [3:0] tag);
    return (t.ac && tag == t.arob) || (t.lc && tag == t.lrob);
  endfunction

  function automatic logic [31:0] bval(input in_t t, input logic [3:0] tag);
    return (t.ac && tag == t.arob) ? t.ares : t.lres;
  endfunction

  // Reference: an entry list; the oldest-indexed ready entry leaves, new work takes the first hole
  task automatic model_step(input in_t t);
    int sel, fr;
    bit fullp;
    if (t.rst || t.clr) begin
      for (int k = 0; k < 8; k++) m[k].busy = 1'b0;
      ev = 0; evi = 0; evj = 0; erob = 0; eop = 0; eopt = 0; eadd = 0;
    end else if (t.rdy) begin
      sel = -1; fr = -1; fullp = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (!m[k].busy) begin
          fullp = 1'b0;
          if (fr < 0) fr = k;
        end else if (sel < 0 && (!m[k].pi || (BYP && hit(t, m[k].qi)))
                              && (!m[k].pj || (BYP && hit(t, m[k].qj)))) sel = k;
      end
      ev = (sel >= 0);
      if (sel >= 0) begin
        evi = m[sel].pi ? bval(t, m[sel].qi) : m[sel].vi;
        evj = m[sel].pj ? bval(t, m[sel].qj) : m[sel].vj;
        erob = m[sel].rob; eop = m[sel].op; eopt = m[sel].opt; eadd = m[sel].add;
      end
      for (int k = 0; k < 8; k++) if (m[k].busy) begin
        if (m[k].pi && hit(t, m[k].qi)) begin m[k].vi = bval(t, m[k].qi); m[k].pi = 1'b0; end
        if (m[k].pj && hit(t, m[k].qj)) begin m[k].vj = bval(t, m[k].qj); m[k].pj = 1'b0; end
      end
      if (sel >= 0) m[sel].busy = 1'b0;
      if (t.dv && !fullp) begin
        m[fr].busy = 1'b1; m[fr].qi = t.qi; m[fr].qj = t.qj; m[fr].rob = t.rob;
        m[fr].op = t.op; m[fr].opt = t.opt; m[fr].add = t.add;
        m[fr].pi = t.hqi && !hit(t, t.qi);
        m[fr].pj = t.hqj && !hit(t, t.qj);
        m[fr].vi = t.hqi ? bval(t, t.qi) : t.dvi;
        m[fr].vj = t.hqj ? bval(t, t.qj) : t.dvj;
      end
    end
  endtask

  function automatic bit model_full();
    bit f = 1'b1;
    for (int k = 0; k < 8; k++) if (!m[k].busy) f = 1'b0;
    return f;
  endfunction

  initial begin
    in_t t;
    vec_t v;
    int idx;
    drive(idle());

    t = idle(); t.rst = 1'b1;
    tbl.push_back(rz(t));
    // plain ADD, no dependencies
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 5, 7, 0, 0, 0, 0, 3), 0));
    tbl.push_back(ex(idle(), 1, 5, 7, 3, 0, 0));
    tbl.push_back(nx(idle(), 0));
    // SUB waiting on tag 2 from the ALU bus
    tbl.push_back(nx(dsp(idle(), 0, ALU, 1, 'h55, 1, 1, 2, 0, 0, 4), 0));
    tbl.push_back(nx(idle(), 0));
    wake_pair(alu(idle(), 2, 10), 10, 1, 4, 1);
    tbl.push_back(nx(idle(), 0));
    // branch whose vj arrives on the LSB bus in the dispatch cycle
    tbl.push_back(nx(lsb(dsp(idle(), 4, BR, 0, 3, 'h1234, 0, 0, 1, 5, 6), 5, 'hFFFF_FFFF), 0));
    v = ex(idle(), 1, 3, 'hFFFF_FFFF, 6, 0, 0); v.e_op = 3'd4; v.e_opt = 7'(BR);
    tbl.push_back(v);
    tbl.push_back(nx(idle(), 0));
    // tag 0: no capture without pending flag, capture with it
    tbl.push_back(nx(alu(dsp(idle(), 0, ALU, 0, 11, 12, 0, 0, 0, 0, 0), 0, 99), 0));
    tbl.push_back(ex(idle(), 1, 11, 12, 0, 0, 0));
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 0, 13, 1, 0, 0, 0, 1), 0));
    wake_pair(alu(idle(), 0, 42), 42, 13, 1, 0);
    // fill all eight on tag 7, ninth dispatch dropped, then drain in index order
    for (int k = 0; k < 8; k++)
      tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 'hdead, k, 1, 7, 0, 0, k), (k == 7) ? 1 : 0));
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 1, 2, 0, 0, 0, 0, 9), 1));
    if (BYP) tbl.push_back(ex(alu(idle(), 7, 100), 1, 100, 0, 0, 0, 0));
    else     tbl.push_back(nx(alu(idle(), 7, 100), 1));
    for (int i = 0; i < 8; i++) begin
      idx = i + int'(BYP);
      if (idx < 8) tbl.push_back(ex(idle(), 1, 100, idx, idx, 0, 0));
      else         tbl.push_back(nx(idle(), 0));
    end
    tbl.push_back(nx(idle(), 0));
    // flush with three waiting entries and an issue in flight
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 0, 0, 1, 9, 0, 0, 2), 0));
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 0, 0, 1, 9, 0, 0, 3), 0));
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 1, 1, 0, 0, 0, 0, 5), 0));
    tbl.push_back(ex(dsp(idle(), 0, ALU, 0, 0, 0, 1, 9, 0, 0, 6), 1, 1, 1, 5, 0, 0));
    t = alu(dsp(idle(), 0, ALU, 0, 4, 4, 0, 0, 0, 0, 13), 9, 50); t.clr = 1'b1;
    tbl.push_back(rz(t));
    tbl.push_back(nx(alu(idle(), 9, 50), 0));
    tbl.push_back(nx(idle(), 0));
    // freeze with rdy low while a ready entry, a wakeup and a dispatch are all offered
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 0, 3, 1, 11, 0, 0, 10), 0));
    tbl.push_back(nx(dsp(idle(), 0, ALU, 0, 20, 21, 0, 0, 0, 0, 7), 0));
    tbl.push_back(ex(dsp(idle(), 0, ALU, 0, 30, 31, 0, 0, 0, 0, 8), 1, 20, 21, 7, 0, 0));
    for (int i = 0; i < 3; i++) begin
      t = alu(dsp(idle(), 0, ALU, 0, 40, 41, 0, 0, 0, 0, 12), 11, 77); t.rdy = 1'b0;
      tbl.push_back(ex(t, 1, 20, 21, 7, 0, 0));
    end
    tbl.push_back(ex(idle(), 1, 30, 31, 8, 0, 0));
    tbl.push_back(nx(idle(), 0));
    wake_pair(alu(idle(), 11, 77), 77, 3, 10, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].i);
      @(posedge clk_in); #1;
      chk($sformatf("row%0d valid", n), 32'(valid), 32'(tbl[n].e_valid));
      chk($sformatf("row%0d full", n), 32'(full), 32'(tbl[n].e_full));
      if (tbl[n].e_valid || tbl[n].chk_all) begin
        chk($sformatf("row%0d vi", n), vi, tbl[n].e_vi);
        chk($sformatf("row%0d vj", n), vj, tbl[n].e_vj);
        chk($sformatf("row%0d rob_entry", n), 32'(rob_entry), 32'(tbl[n].e_rob));
        chk($sformatf("row%0d op", n), 32'(op), 32'(tbl[n].e_op));
        chk($sformatf("row%0d op_type", n), 32'(op_type), 32'(tbl[n].e_opt));
        chk($sformatf("row%0d op_addition", n), 32'(op_addition), 32'(tbl[n].e_add));
      end
    end

    for (int c = 0; c < 1500; c++) begin
      t = idle();
      t.rst = (c == 0) || ($urandom_range(0, 199) == 0);
      t.clr = ($urandom_range(0, 59) == 0);
      t.rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6)
        t = dsp(t, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
                int'($urandom), int'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 3) t = alu(t, int'($urandom_range(0, 3)), int'($urandom));
      if ($urandom_range(0, 9) < 3) t = lsb(t, int'($urandom_range(0, 3)), int'($urandom));
      if (t.ac && t.lc && t.arob == t.lrob) t.lc = 1'b0;
      drive(t);
      model_step(t);
      @(posedge clk_in); #1;
      chk($sformatf("rnd%0d valid", c), 32'(valid), 32'(ev));
      chk($sformatf("rnd%0d full", c), 32'(full), 32'(model_full()));
      if (ev || t.rst || t.clr) begin
        chk($sformatf("rnd%0d vi", c), vi, evi);
        chk($sformatf("rnd%0d vj", c), vj, evj);
        chk($sformatf("rnd%0d rob_entry", c), 32'(rob_entry), 32'(erob));
        chk($sformatf("rnd%0d op", c), 32'(op), 32'(eop));
        chk($sformatf("rnd%0d op_type", c), 32'(op_type), 32'(eopt));
        chk($sformatf("rnd%0d op_addition", c), 32'(op_addition), 32'(eadd));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
